// File: rtl/simon_pkg.sv
// Shared SIMON key-schedule definitions: config codes, n/m/T/z lookup, z sequences, round constant.
package simon_pkg;

    localparam logic [3:0] CFG_32_64   = 4'd0;
    localparam logic [3:0] CFG_48_72   = 4'd1;
    localparam logic [3:0] CFG_48_96   = 4'd2;
    localparam logic [3:0] CFG_64_96   = 4'd3;
    localparam logic [3:0] CFG_64_128  = 4'd4;
    localparam logic [3:0] CFG_96_96   = 4'd5;
    localparam logic [3:0] CFG_96_144  = 4'd6;
    localparam logic [3:0] CFG_128_128 = 4'd7;
    localparam logic [3:0] CFG_128_192 = 4'd8;
    localparam logic [3:0] CFG_128_256 = 4'd9;
    localparam logic [3:0] CFG_LAST    = CFG_128_256;

    localparam int ROUND_CONST = 3;

    // Written in publication order: the MSB is z_j[0].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef struct packed {
        logic [6:0] n;
        logic [2:0] m;
        logic [6:0] t;
        logic [2:0] zj;
    } simon_cfg_t;

    function automatic simon_cfg_t cfg_lookup(input logic [3:0] code);
        simon_cfg_t c;
        case (code)
            CFG_32_64:   c = '{n: 7'd16, m: 3'd4, t: 7'd32, zj: 3'd0};
            CFG_48_72:   c = '{n: 7'd24, m: 3'd3, t: 7'd36, zj: 3'd0};
            CFG_48_96:   c = '{n: 7'd24, m: 3'd4, t: 7'd36, zj: 3'd1};
            CFG_64_96:   c = '{n: 7'd32, m: 3'd3, t: 7'd42, zj: 3'd2};
            CFG_64_128:  c = '{n: 7'd32, m: 3'd4, t: 7'd44, zj: 3'd3};
            CFG_96_96:   c = '{n: 7'd48, m: 3'd2, t: 7'd52, zj: 3'd2};
            CFG_96_144:  c = '{n: 7'd48, m: 3'd3, t: 7'd54, zj: 3'd3};
            CFG_128_128: c = '{n: 7'd64, m: 3'd2, t: 7'd68, zj: 3'd2};
            CFG_128_192: c = '{n: 7'd64, m: 3'd3, t: 7'd69, zj: 3'd3};
            CFG_128_256: c = '{n: 7'd64, m: 3'd4, t: 7'd72, zj: 3'd4};
            default:     c = '0;
        endcase
        return c;
    endfunction

    function automatic logic z_bit(input logic [2:0] j, input logic [5:0] pos);
        logic [5:0] b;
        b = 6'd61 - pos;
        case (j)
            3'd0:    return Z0[b];
            3'd1:    return Z1[b];
            3'd2:    return Z2[b];
            3'd3:    return Z3[b];
            default: return Z4[b];
        endcase
    endfunction

endpackage

// File: rtl/simon_kexp_step.sv
// Combinational SIMON key-schedule step: k[i] from the last four words (win[3] = k[i-1] .. win[0] = k[i-4]).
module simon_kexp_step
    import simon_pkg::*;
#(
    parameter int W     = 64,
    parameter int IDX_W = 7
) (
    input  logic [6:0]        n,
    input  logic [2:0]        m,
    input  logic [2:0]        zj,
    input  logic [IDX_W-1:0]  i,
    input  logic [3:0][W-1:0] win,
    output logic [W-1:0]      word
);

    logic [W-1:0]     mask;
    logic [W-1:0]     t0;
    logic [W-1:0]     t1;
    logic [W-1:0]     km;
    logic [IDX_W-1:0] d;
    logic [5:0]       pos;

    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [6:0] r,
                                         input logic [6:0] nn, input logic [W-1:0] msk);
        return ((x >> r) | (x << (nn - r))) & msk;
    endfunction

    always_comb begin
        mask = ~({W{1'b1}} << n);
        d    = i - IDX_W'(m);
        if (d >= IDX_W'(62)) begin
            d = d - IDX_W'(62);
        end
        pos = d[5:0];
        t0  = ror(win[3], 7'd3, n, mask);
        if (m == 3'd4) begin
            t0 = t0 ^ win[1];
        end
        t1 = t0 ^ ror(t0, 7'd1, n, mask);
        case (m)
            3'd2:    km = win[2];
            3'd3:    km = win[1];
            default: km = win[0];
        endcase
        word = (~km ^ t1 ^ W'(z_bit(zj, pos)) ^ W'(ROUND_CONST)) & mask;
    end

endmodule

// File: rtl/simon_kexp_multi.sv
// SIMON key expansion for all ten 2n/mn configs at one round key per cycle, served by a registered read port.
// exp_valid rises T-m+1 cycles after accept; k_ready is low while expanding. SIMON_KEXP_STREAM_EN adds rks_*.
module simon_kexp_multi
    import simon_pkg::*;
#(
    parameter int MAX_WORD_WIDTH = 64,
    parameter int MAX_ROUNDS     = 72,
    parameter int KEY_WIDTH      = 256,
    parameter int IDX_W          = 7
) (
    input  logic                      ck,
    input  logic                      nrst,
    input  logic [3:0]                cfg,
    input  logic [KEY_WIDTH-1:0]      key,
    input  logic                      k_valid,
    output logic                      k_ready,
    output logic                      cfg_err,
    output logic                      exp_valid,
    output logic [IDX_W-1:0]          rk_rounds,
    input  logic [IDX_W-1:0]          rk_idx,
    output logic [MAX_WORD_WIDTH-1:0] rk_data
`ifdef SIMON_KEXP_STREAM_EN
    ,
    output logic                      rks_valid,
    output logic [IDX_W-1:0]          rks_idx,
    output logic [MAX_WORD_WIDTH-1:0] rks_data
`endif
);

    localparam int W = MAX_WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    simon_cfg_t        cur;
    simon_cfg_t        lk;
    logic              legal;
    logic              offer;
    logic              accept;
    logic              exp_wr;
    logic [IDX_W-1:0]  idx;
    logic [3:0][W-1:0] win;
    logic [3:0][W-1:0] key_words;
    logic [W-1:0]      lk_mask;
    logic [W-1:0]      nxt_word;
    logic [W-1:0]      store [MAX_ROUNDS];

    assign lk        = cfg_lookup(cfg);
    assign legal     = (cfg <= CFG_LAST) && (int'(lk.n) <= MAX_WORD_WIDTH) &&
                       (int'(lk.t) <= MAX_ROUNDS) && (int'(lk.m) * int'(lk.n) <= KEY_WIDTH);
    assign k_ready   = (state != EXP);
    assign exp_valid = (state == DONE);
    assign offer     = k_valid & k_ready;
    assign accept    = offer & legal;
    assign exp_wr    = (state == EXP) && (idx < IDX_W'(cur.t));

    always_comb begin
        lk_mask = ~({W{1'b1}} << lk.n);
        for (int j = 0; j < 4; j++) begin
            key_words[j] = W'(key >> (j * int'(lk.n))) & lk_mask;
        end
    end

    always_ff @(posedge ck) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // EXP lingers one cycle after the last write so the T-th word is settled before DONE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (accept) state_nx = EXP;
            EXP:        if (!exp_wr) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!nrst) begin
            cfg_err   <= 1'b0;
            rk_rounds <= '0;
            cur       <= '0;
            idx       <= '0;
        end else begin
            cfg_err <= offer & ~legal;
            if (accept) begin
                cur       <= lk;
                rk_rounds <= IDX_W'(lk.t);
                idx       <= IDX_W'(lk.m);
            end else if (exp_wr) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    simon_kexp_step #(.W(W), .IDX_W(IDX_W)) u_step (
        .n    (cur.n),
        .m    (cur.m),
        .zj   (cur.zj),
        .i    (idx),
        .win  (win),
        .word (nxt_word)
    );

    // The key words land right-aligned in the window so win[3] is always k[i-1].
    always_ff @(posedge ck) begin
        if (accept) begin
            for (int s = 0; s < 4; s++) begin
                win[s] <= (s + int'(lk.m) >= 4) ? key_words[2'(s + int'(lk.m) - 4)] : '0;
            end
            for (int j = 0; j < 4; j++) begin
                if (j < int'(lk.m)) store[j] <= key_words[j];
            end
        end else if (exp_wr) begin
            store[idx] <= nxt_word;
            win        <= {nxt_word, win[3], win[2], win[1]};
        end
    end

    always_ff @(posedge ck) begin
        if (!nrst) begin
            rk_data <= '0;
        end else begin
            rk_data <= (rk_idx < rk_rounds) ? store[rk_idx] : '0;
        end
    end

`ifdef SIMON_KEXP_STREAM_EN
    logic [IDX_W-1:0] rks_ptr;
    logic             rks_run;

    // Word s is emitted s cycles after accept; it was written at least one cycle earlier for s >= m.
    // A new accept restarts the stream even if the previous one is still draining.
    always_ff @(posedge ck) begin
        if (!nrst) begin
            rks_valid <= 1'b0;
            rks_idx   <= '0;
            rks_data  <= '0;
            rks_ptr   <= '0;
            rks_run   <= 1'b0;
        end else if (accept) begin
            rks_valid <= 1'b1;
            rks_idx   <= '0;
            rks_data  <= key_words[0];
            rks_ptr   <= IDX_W'(1);
            rks_run   <= 1'b1;
        end else if (rks_run) begin
            rks_valid <= 1'b1;
            rks_idx   <= rks_ptr;
            rks_data  <= store[rks_ptr];
            rks_ptr   <= rks_ptr + IDX_W'(1);
            rks_run   <= (rks_ptr + IDX_W'(1) < rk_rounds);
        end else begin
            rks_valid <= 1'b0;
        end
    end
`endif

endmodule
